// File: rtl/even_sweep_ctrl.sv
// even_sweep_ctrl: owns an even-only up/down counter (q[0] is always 0) and
// runs a requested number of ping-pong sweeps 0 -> MAX -> 0, with
// MAX = 2^WIDTH-2.
//
// Handshake: start is sampled only in IDLE, together with a non-zero sweeps
// value. busy is high for every cycle spent in UP or DOWN. done is a
// one-cycle pulse after the last sweep lands on 0. pause freezes progress,
// and abort (which beats pause) returns to IDLE without a done pulse.
// While busy or done, start is ignored and sweeps is not re-sampled.
module even_sweep_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SWEEPW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SWEEPW-1:0] sweeps,
    input  logic              pause,
    input  logic              abort,
    output logic [WIDTH-1:0]  q,
    output logic              y,
    output logic              busy,
    output logic              done,
    output logic [SWEEPW-1:0] sweeps_left,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Largest even value that fits in WIDTH bits.
    localparam logic [WIDTH-1:0]  MAX     = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0]  STEP    = WIDTH'(2);
    localparam logic [WIDTH-1:0]  TURN_UP = MAX - STEP;
    localparam logic [SWEEPW-1:0] ONE     = SWEEPW'(1);

    state_t state;

    assign state_dbg = state;

    // Sweep FSM. The counter, direction and status outputs are all
    // registered here, so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            q           <= '0;
            y           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sweeps_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // abort is meaningless here, so a start issued with it still launches.
                    if (start && (sweeps != '0)) begin
                        state       <= UP;
                        busy        <= 1'b1;
                        sweeps_left <= sweeps;
                        q           <= '0;
                        y           <= 1'b0;
                    end
                end
                UP: begin
                    if (abort) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        q           <= '0;
                        y           <= 1'b0;
                        sweeps_left <= '0;
                    end else if (!pause) begin
                        q <= q + STEP;
                        // Turn around so that q=MAX and y=1 appear together.
                        if (q == TURN_UP) begin
                            state <= DOWN;
                            y     <= 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (abort) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        q           <= '0;
                        y           <= 1'b0;
                        sweeps_left <= '0;
                    end else if (!pause) begin
                        q <= q - STEP;
                        // Landing on 0 completes one round trip.
                        if (q == STEP) begin
                            sweeps_left <= sweeps_left - ONE;
                            y           <= 1'b0;
                            if (sweeps_left == ONE) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= UP;
                            end
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    done        <= 1'b0;
                    q           <= '0;
                    sweeps_left <= '0;
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    q           <= '0;
                    y           <= 1'b0;
                    sweeps_left <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/even_sweep_ctrl.md
Name: even_sweep_ctrl

Overview:
- Sequencing controller for the even up-down binary counter datapath. It owns the even counter state (q[0] always 0) and drives its direction bit y automatically.
- Performs a requested number of ping-pong sweeps: 0 up to MAX, then back down to 0. MAX = 2^WIDTH-2.
- Start/busy/done handshake lets a higher-level controller launch sweeps without toggling y by hand.
- Supports pause and abort.

Parameters:
- WIDTH, 4, counter width in bits; MAX = 2^WIDTH-2 (14 at default).
- SWEEPW, 4, width of the sweep-count input and of the remaining-sweeps output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  input  1  launch request; sampled only in IDLE.
- sweeps  input  SWEEPW  number of full round trips; sampled with start.
- pause  input  1  freezes sweep progress while high.
- abort  input  1  terminates a sweep in progress.
- q  output  WIDTH  counter value; always even.
- y  output  1  direction: 0 = up, 1 = down.
- busy  output  1  high in UP or DOWN.
- done  output  1  one-cycle pulse after the last sweep completes.
- sweeps_left  output  SWEEPW  round trips remaining, including the current one.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, q=0, y=0, busy=0, done=0, sweeps_left=0. Reset mid-sweep aborts at once with no done pulse.
- FSM states: IDLE, UP, DOWN, DONE. busy = (state==UP || state==DOWN); done = (state==DONE). Both outputs are registered/state-decoded, with no combinational path from the inputs.
- IDLE: q=0, y=0.
  - start=1 && sweeps!=0 at an edge -> UP, sweeps_left<=sweeps.
  - start=1 && sweeps==0 -> ignored; stay IDLE.
- UP, each edge with pause=0 and abort=0: q<=q+2.
  - If q==MAX-2 at that edge, also state<=DOWN and y<=1, so q=MAX and y=1 appear together.
- DOWN, each edge with pause=0 and abort=0: q<=q-2.
  - If q==2 at that edge: q<=0, sweeps_left<=sweeps_left-1.
  - If sweeps_left==1: state<=DONE, y<=0.
  - Otherwise: state<=UP, y<=0.
- DONE: lasts exactly one cycle; next edge -> IDLE. q=0, sweeps_left=0.
- Timing at default WIDTH:
  - start edge E0 -> busy=1, q=0.
  - q reaches 14 at E7, returns to 0 at E14. One sweep = 14 cycles.
  - N sweeps: busy high for 14*N cycles; done high for the cycle after edge E(14*N); IDLE at E(14*N+1).
- pause=1 in UP/DOWN: q, y, state and sweeps_left hold. No effect in IDLE/DONE.
- abort=1 in UP/DOWN: next edge q<=0, y<=0, sweeps_left<=0, state<=IDLE, with no done pulse.
  - abort has priority over pause and over the MAX/zero turn-around.
  - abort is ignored in IDLE/DONE.
- start while busy or in DONE: ignored; the sweeps input is not re-sampled.
- Range: q never exceeds MAX and never wraps. The odd values and 2^WIDTH-1 are unreachable.
- Simultaneous start and abort in IDLE: start wins, since abort is meaningless in IDLE.

Test Plan:
- Reset: hold reset=0 for 10 time units, then release -> q=0000, y=0, busy=0, done=0, sweeps_left=0. Assert reset=0 asynchronously mid-UP at q=0110 -> all outputs return to reset values before the next clk edge.
- Single sweep: sweeps=1, start pulse -> q sequence 0,2,4,...,14,12,...,0 over 14 cycles; y=1 exactly while q steps 14->0; done=1 for one cycle; IDLE next.
- Multi-sweep: sweeps=3 -> sweeps_left reads 3,2,1 at each return to 0; busy high for 42 cycles; a single done pulse at the end.
- Pause: pause=1 for 5 cycles while DOWN at q=1000 -> q stays 1000 and y stays 1; on release q continues 0110; total busy length grows by 5.
- Abort: abort=1 in UP at q=1010 -> next edge q=0000, busy=0, no done pulse. Abort in IDLE -> no change.
- Ignored requests: start with sweeps=0 -> stays IDLE. Start pulse mid-sweep with sweeps=7 -> sweeps_left unchanged and the sequence is unaffected.
